leaf_accum_stage: RTL and testbench

Leaf-level streaming accumulator that sits beneath the deepest level of the generated `rootModule_*` hierarchy. The hierarchy levels are pure instantiation shells; this block is the sequential leaf they instantiate. It accepts a valid/ready sample stream, sums groups of `COUNT` samples, and presents each group sum on a registered valid/ready output. A flush input closes a partial group early.

---
 rtl/leaf_accum_stage.sv | 103 ++++++++++
 tb/tb_leaf_accum_stage.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/leaf_accum_stage.sv
// Streaming leaf accumulator: sums groups of COUNT samples, flush closes a partial group early.
// Optional clamp-on-overflow with sticky per-group flag when LEAF_ACCUM_SAT_EN is defined.
module leaf_accum_stage #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COUNT  = 4,
  parameter int unsigned SUM_W  = 9,
  parameter int unsigned CNT_W  = $clog2(COUNT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_sat
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state;
  logic [SUM_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             close;
  logic [SUM_W-1:0] red_sum;
  logic [SUM_W-1:0] close_sum;
  logic [CNT_W-1:0] eff_cnt;

`ifdef LEAF_ACCUM_SAT_EN
  logic [SUM_W:0] nsum;
  logic           clamp;
  logic           sat_flag;
`endif

  // Output slot frees up when empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
`ifdef LEAF_ACCUM_SAT_EN
    nsum    = (SUM_W + 1)'(acc) + (SUM_W + 1)'(in_data);
    clamp   = nsum[SUM_W];
    red_sum = clamp ? {SUM_W{1'b1}} : nsum[SUM_W-1:0];
`else
    red_sum = acc + SUM_W'(in_data);
`endif
    eff_cnt   = accept ? cnt + CNT_W'(1) : cnt;
    close_sum = accept ? red_sum : acc;
    close     = (accept && (cnt == CNT_W'(COUNT - 1))) ||
                (flush && in_ready && (eff_cnt != '0));
  end

  // Group state, output registers and ACCUM/HOLD control.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cnt   <= '0;
    end else if (close) begin
      state     <= HOLD;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b1;
      out_sum   <= close_sum;
      out_cnt   <= eff_cnt;
    end else begin
      if (accept) begin
        acc <= red_sum;
        cnt <= cnt + CNT_W'(1);
      end
      if (state == HOLD && out_ready) begin
        state     <= ACCUM;
        out_valid <= 1'b0;
      end
    end
  end

`ifdef LEAF_ACCUM_SAT_EN
  // Sticky clamp flag for the open group, published with the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
      out_sat  <= 1'b0;
    end else if (close) begin
      sat_flag <= 1'b0;
      out_sat  <= sat_flag || (accept && clamp);
    end else if (accept && clamp) begin
      sat_flag <= 1'b1;
    end
  end
`else
  assign out_sat = 1'b0;
`endif

endmodule

// File: tb/tb_leaf_accum_stage.sv
// Directed bench for leaf_accum_stage: default instance plus a COUNT=1 instance.
module tb_leaf_accum_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_sum;
  logic [2:0] out_cnt;
  logic       out_sat;

  logic       b_in_valid;
  logic [7:0] b_in_data;
  logic       b_in_ready;
  logic       b_flush;
  logic       b_out_valid;
  logic       b_out_ready;
  logic [8:0] b_out_sum;
  logic [0:0] b_out_cnt;
  logic       b_out_sat;

  int total = 0;
  int bad   = 0;

`ifdef LEAF_ACCUM_SAT_EN
  localparam int unsigned OVF_SUM = 511;
  localparam int unsigned OVF_SAT = 1;
`else
  localparam int unsigned OVF_SUM = 508;
  localparam int unsigned OVF_SAT = 0;
`endif

  always #5 clk = ~clk;

  leaf_accum_stage u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cnt(out_cnt), .out_sat(out_sat)
  );

  leaf_accum_stage #(.DATA_W(8), .COUNT(1), .SUM_W(9), .CNT_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
    .out_cnt(b_out_cnt), .out_sat(b_out_sat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input int v, input int s, input int c, input int sat);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".sum"},   32'(out_sum),   32'(s));
    check({tag, ".cnt"},   32'(out_cnt),   32'(c));
    check({tag, ".sat"},   32'(out_sat),   32'(sat));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_flush = 1'b0; b_out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    check_out("reset", 0, 0, 0, 0);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.b_valid", 32'(b_out_valid), 32'd0);

    // Basic group
    out_ready = 1'b1;
    send(1); send(2); send(3);
    check("basic.pre_valid", 32'(out_valid), 32'd0);
    send(4);
    check_out("basic", 1, 10, 4, 0);
    step();
    check("basic.drain", 32'(out_valid), 32'd0);

    // Backpressure
    send(1); send(1); send(1);
    out_ready = 1'b0;
    send(1);
    check_out("bp.close", 1, 4, 4, 0);
    in_valid = 1'b1; in_data = 8'd50;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp.in_ready", 32'(in_ready), 32'd0);
      step();
      check_out("bp.hold", 1, 4, 4, 0);
    end
    out_ready = 1'b1; in_data = 8'd7;
    #1;
    check("bp.in_ready_release", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("bp.handshake", 32'(out_valid), 32'd0);
    send(1); send(1); send(1);
    check_out("bp.next", 1, 10, 4, 0);
    step();

    // Flush
    send(5); send(6);
    flush = 1'b1; step(); flush = 1'b0;
    check_out("flush.alone", 1, 11, 2, 0);
    step();
    send(5); send(6);
    flush = 1'b1; send(9); flush = 1'b0;
    check_out("flush.with", 1, 20, 3, 0);
    step();
    check("flush.drain", 32'(out_valid), 32'd0);
    flush = 1'b1; step(); flush = 1'b0;
    check("flush.empty", 32'(out_valid), 32'd0);
    step();
    check("flush.empty2", 32'(out_valid), 32'd0);

    // Overflow
    send(255); send(255); send(255); send(255);
    check_out("ovf", 1, int'(OVF_SUM), 4, int'(OVF_SAT));
    step();
    send(1); send(1); send(1); send(1);
    check_out("ovf.next", 1, 4, 4, 0);
    step();

    // Reset mid-group
    send(3); send(3);
    rst = 1'b1; step(); rst = 1'b0;
    check_out("rst.mid", 0, 0, 0, 0);
    send(1); send(1); send(1);
    check_out("rst.after", 0, 0, 0, 0);
    send(1);
    check_out("rst.result", 1, 4, 4, 0);
    step();

    // COUNT=1 streaming
    b_in_valid = 1'b1;
    b_in_data = 8'd9; step();
    check("c1.v0", 32'(b_out_valid), 32'd1);
    check("c1.s0", 32'(b_out_sum), 32'd9);
    check("c1.c0", 32'(b_out_cnt), 32'd1);
    b_in_data = 8'd8; step();
    check("c1.v1", 32'(b_out_valid), 32'd1);
    check("c1.s1", 32'(b_out_sum), 32'd8);
    check("c1.c1", 32'(b_out_cnt), 32'd1);
    b_in_data = 8'd7; step();
    check("c1.v2", 32'(b_out_valid), 32'd1);
    check("c1.s2", 32'(b_out_sum), 32'd7);
    check("c1.c2", 32'(b_out_cnt), 32'd1);
    b_in_valid = 1'b0; step();
    check("c1.drain", 32'(b_out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
